// File: rtl/pmp_pipe_checker.sv
// pmp_pipe_checker: CSR-programmed PMP entries checked by independent two-stage valid/ready channels.
module pmp_pipe_checker #(
    parameter int PMP_ENTRIES  = 16,
    parameter int REQ_CHANNELS = 3,
    parameter int ADDR_WIDTH   = 34,
    parameter int PMP_G        = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             csr_we,
    input  logic                             csr_re,
    input  logic [11:0]                      csr_addr,
    input  logic [31:0]                      csr_wdata,
    output logic [31:0]                      csr_rdata,
    output logic                             csr_rvalid,
    output logic                             csr_err,
    input  logic [1:0]                       priv_mode,
    input  logic [REQ_CHANNELS-1:0]          req_valid,
    output logic [REQ_CHANNELS-1:0]          req_ready,
    input  logic [REQ_CHANNELS*ADDR_WIDTH-1:0] req_addr,
    input  logic [REQ_CHANNELS*2-1:0]        req_type,
    output logic [REQ_CHANNELS-1:0]          rsp_valid,
    input  logic [REQ_CHANNELS-1:0]          rsp_ready,
    output logic [REQ_CHANNELS-1:0]          rsp_pass,
    output logic [REQ_CHANNELS-1:0]          rsp_hit,
    output logic [REQ_CHANNELS*6-1:0]        rsp_entry
);
    localparam int AL = ADDR_WIDTH - 2;
    localparam int NC = PMP_ENTRIES / 4;
    localparam logic [31:0] M_NAPOT = (32'h1 << (PMP_G >= 2 ? PMP_G - 1 : 0)) - 32'h1;
    localparam logic [31:0] M_OFF = PMP_G >= 2 ? (32'h1 << PMP_G) - 32'h1 : 32'h0;

    logic [7:0]              cfg [PMP_ENTRIES];
    logic [AL-1:0]           pa [PMP_ENTRIES];
    logic [AL-1:0]           lo [PMP_ENTRIES];
    logic [PMP_ENTRIES:0]    tor_lock;
    logic                    csr_bad;
    logic [31:0]             rd;
    logic [REQ_CHANNELS-1:0] m_hit, s1_valid, s1_hit, s2_load;
    logic [5:0]              m_idx [REQ_CHANNELS];
    logic [5:0]              s1_idx [REQ_CHANNELS];
    logic [3:0]              m_lrwx [REQ_CHANNELS];
    logic [3:0]              s1_lrwx [REQ_CHANNELS];
    logic [1:0]              s1_type [REQ_CHANNELS];
    logic [1:0]              s1_priv [REQ_CHANNELS];

    function automatic logic [7:0] cfg_legal(input logic [7:0] w);
        logic [1:0] a;
        a = (PMP_G >= 1 && w[4:3] == 2'b10) ? 2'b00 : w[4:3];
        return {w[7], 2'b00, a, w[2], w[1] & w[0], w[0]};
    endfunction

    function automatic logic [31:0] addr_view(input logic [AL-1:0] p, input logic [1:0] a);
        logic [31:0] v;
        v = 32'(p);
        return a == 2'b11 ? v | M_NAPOT : !a[1] ? v & ~M_OFF : v;
    endfunction

    function automatic logic entry_match(input logic [AL-1:0] a, input logic [AL-1:0] l,
                                         input logic [AL-1:0] p, input logic [1:0] m);
        logic [AL-1:0] t;
        t = (p + 1'b1) & ~p;
        return m == 2'b01 ? (l < p && a >= l && a < p) :
               m == 2'b10 ? a == p :
               m == 2'b11 ? ((a ^ p) & ~(t | (t - 1'b1))) == '0 : 1'b0;
    endfunction

    assign csr_bad = priv_mode != 2'b11 || csr_addr < 12'h3A0 || csr_addr > 12'h3EF;

    always_comb begin
        tor_lock = '0;
        rd = '0;
        lo[0] = '0;
        for (int i = 1; i < PMP_ENTRIES; i++) lo[i] = pa[i-1];
        for (int i = 0; i < PMP_ENTRIES; i++) begin
            tor_lock[i] = cfg[i][7] && cfg[i][4:3] == 2'b01;
            if (csr_addr == 12'(12'h3B0 + i)) rd = addr_view(pa[i], cfg[i][4:3]);
        end
        for (int k = 0; k < NC; k++)
            if (csr_addr == 12'(12'h3A0 + k)) rd = {cfg[4*k+3], cfg[4*k+2], cfg[4*k+1], cfg[4*k]};
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        for (int c = 0; c < REQ_CHANNELS; c++) begin
            m_hit[c] = 1'b0;
            m_idx[c] = '0;
            m_lrwx[c] = '0;
            for (int i = PMP_ENTRIES - 1; i >= 0; i--)
                if (entry_match(req_addr[c*ADDR_WIDTH+2 +: AL], lo[i], pa[i], cfg[i][4:3])) begin
                    m_hit[c] = 1'b1;
                    m_idx[c] = 6'(i);
                    m_lrwx[c] = {cfg[i][7], cfg[i][2:0]};
                end
            s2_load[c] = !rsp_valid[c] || rsp_ready[c];
            req_ready[c] = !s1_valid[c] || s2_load[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PMP_ENTRIES; i++) begin
                cfg[i] <= '0;
                pa[i] <= '0;
            end
            csr_rdata <= '0;
            csr_rvalid <= 1'b0;
            csr_err <= 1'b0;
        end else begin
            csr_rvalid <= csr_re;
            csr_err <= (csr_we || csr_re) && csr_bad;
            csr_rdata <= csr_re && !csr_bad ? rd : '0;
            for (int i = 0; i < PMP_ENTRIES; i++) begin
                if (csr_we && !csr_bad && csr_addr == 12'(12'h3A0 + i / 4) && !cfg[i][7])
                    cfg[i] <= cfg_legal(csr_wdata[8*(i%4) +: 8]);
                if (csr_we && !csr_bad && csr_addr == 12'(12'h3B0 + i) && !cfg[i][7] && !tor_lock[i+1])
                    pa[i] <= AL'(csr_wdata);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= '0;
            s1_hit <= '0;
            rsp_valid <= '0;
            rsp_pass <= '0;
            rsp_hit <= '0;
            rsp_entry <= '0;
            for (int c = 0; c < REQ_CHANNELS; c++) begin
                s1_idx[c] <= '0;
                s1_lrwx[c] <= '0;
                s1_type[c] <= '0;
                s1_priv[c] <= '0;
            end
        end else begin
            for (int c = 0; c < REQ_CHANNELS; c++) begin
                if (req_ready[c]) s1_valid[c] <= req_valid[c];
                if (req_ready[c] && req_valid[c]) begin
                    s1_hit[c] <= m_hit[c];
                    s1_idx[c] <= m_idx[c];
                    s1_lrwx[c] <= m_lrwx[c];
                    s1_type[c] <= req_type[c*2 +: 2];
                    s1_priv[c] <= priv_mode;
                end
                if (s2_load[c]) begin
                    rsp_valid[c] <= s1_valid[c];
                    if (s1_valid[c]) begin
                        rsp_hit[c] <= s1_hit[c];
                        rsp_entry[c*6 +: 6] <= s1_idx[c];
                        rsp_pass[c] <= s1_hit[c] ?
                            (s1_priv[c] == 2'b11 && !s1_lrwx[c][3]) ||
                            (s1_type[c] != 2'b00 && s1_lrwx[c][s1_type[c] - 2'b01]) :
                            s1_priv[c] == 2'b11;
                    end
                end
            end
        end
    end
endmodule
